// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, byte-addressed memory between the
// instruction-fetch unit (IF) and the load/store unit (LS).
// Every granted access takes three cycles: IDLE (arbitrate and latch),
// ACCESS (drive memory), RESP (one-cycle ack carrying registered data).
// LS normally wins arbitration. IF is forced through once LS has been
// granted IF_STARVE_MAX times in a row while IF was waiting.
// Optional build macro: MEM_ARB_MISALIGN_TRAP_EN. When it is defined,
// misaligned LS half and word accesses are rejected like boundary errors.
module mem_port_arbiter #(
  parameter int IF_STARVE_MAX = 4,
  parameter int AW            = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [31:0]   if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic          ls_ba,
  input  logic          ls_ha,
  input  logic          ls_ua,
  input  logic [AW-1:0] ls_addr,
  input  logic [31:0]   ls_wdata,
  output logic          ls_ack,
  output logic [31:0]   ls_rdata,
  output logic          ls_err,
  output logic          mem_wena,
  output logic          mem_ba,
  output logic          mem_ha,
  output logic          mem_ua,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout
);

  localparam int AW1 = AW + 1;
  localparam int SW  = (IF_STARVE_MAX < 1) ? 1 : $clog2(IF_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(IF_STARVE_MAX);
  // Highest byte address, widened by one bit so that address arithmetic
  // cannot wrap before it is compared.
  localparam logic [AW:0]   TOP_ADDR   = {1'b0, {AW{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_starve;
  logic            r_is_if;
  logic            r_we;
  logic            r_ba;
  logic            r_ha;
  logic            r_ua;
  logic            r_err;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;

  logic            w_if_prio;
  logic            w_grant_ls;
  logic            w_grant_if;
  logic [AW:0]     w_size_m1;
  logic [AW:0]     w_last;
  logic            w_bound_err;
  logic            w_misalign;

  // Size-extend a load: byte and half take bit 7 or bit 15 as the sign
  // unless the unsigned flag is set. A word passes through unchanged.
  function automatic logic [31:0] f_load_ext(input logic [31:0] dout,
                                             input logic        ext_ba,
                                             input logic        ext_ha,
                                             input logic        ext_ua);
    logic [31:0] v;
    v = dout;
    if (ext_ba) begin
      v = {{24{~ext_ua & dout[7]}}, dout[7:0]};
    end else if (ext_ha) begin
      v = {{16{~ext_ua & dout[15]}}, dout[15:0]};
    end else begin
      v = dout;
    end
    return v;
  endfunction

  // Fetch near the top of memory: any byte past the last address reads as
  // zero, whatever the memory returns for it (there is no wrap to address 0).
  function automatic logic [31:0] f_fetch_clip(input logic [31:0]   dout,
                                               input logic [AW-1:0] addr);
    logic [31:0] v;
    v = dout;
    for (int k = 0; k < 4; k++) begin
      if (({1'b0, addr} + AW1'(k)) > TOP_ADDR) begin
        v[8*k +: 8] = 8'h00;
      end else begin
        v[8*k +: 8] = dout[8*k +: 8];
      end
    end
    return v;
  endfunction

  // LS rejection checks: the last byte of the access must not run past the
  // top address.
  assign w_size_m1   = ls_ba ? AW1'(0) : (ls_ha ? AW1'(1) : AW1'(3));
  assign w_last      = {1'b0, ls_addr} + w_size_m1;
  assign w_bound_err = (w_last > TOP_ADDR);

`ifdef MEM_ARB_MISALIGN_TRAP_EN
  assign w_misalign = ~ls_ba & ((ls_ha & ls_addr[0]) |
                                (~ls_ha & (ls_addr[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  // Arbitration: LS has priority unless IF has been starved to the limit.
  always_comb begin
    w_if_prio  = if_req & (r_starve == STARVE_MAX);
    w_grant_ls = 1'b0;
    w_grant_if = 1'b0;
    if (r_state == ST_IDLE) begin
      w_grant_ls = ls_req & ~w_if_prio;
      w_grant_if = if_req & ~w_grant_ls;
    end else begin
      w_grant_ls = 1'b0;
      w_grant_if = 1'b0;
    end
  end

  // Next-state logic for the IDLE -> ACCESS -> RESP cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_ls | w_grant_if) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register. Reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Starvation counter: counts LS grants made while IF waits, and saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= {SW{1'b0}};
    end else if (r_state == ST_IDLE) begin
      if (w_grant_if | ~if_req) begin
        r_starve <= {SW{1'b0}};
      end else if (w_grant_ls && (r_starve != STARVE_MAX)) begin
        r_starve <= r_starve + SW'(1'b1);
      end
    end
  end

  // Latch the winner's request. IF is always a plain word read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_if <= 1'b0;
      r_we    <= 1'b0;
      r_ba    <= 1'b0;
      r_ha    <= 1'b0;
      r_ua    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= {AW{1'b0}};
      r_wdata <= 32'h0000_0000;
    end else if (w_grant_ls) begin
      r_is_if <= 1'b0;
      r_we    <= ls_we;
      r_ba    <= ls_ba;
      r_ha    <= ls_ha & ~ls_ba;
      r_ua    <= ls_ua;
      r_err   <= w_bound_err | w_misalign;
      r_addr  <= ls_addr;
      r_wdata <= ls_we ? ls_wdata : 32'h0000_0000;
    end else if (w_grant_if) begin
      r_is_if <= 1'b1;
      r_we    <= 1'b0;
      r_ba    <= 1'b0;
      r_ha    <= 1'b0;
      r_ua    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= if_addr;
      r_wdata <= 32'h0000_0000;
    end
  end

  // Memory controls: driven only during ACCESS. A write is blocked while
  // reset is high or when the access was rejected.
  always_comb begin
    mem_wena = 1'b0;
    mem_ba   = 1'b0;
    mem_ha   = 1'b0;
    mem_ua   = 1'b0;
    mem_addr = {AW{1'b0}};
    mem_din  = 32'h0000_0000;
    if (r_state == ST_ACCESS) begin
      mem_wena = r_we & ~r_err & ~rst;
      mem_ba   = r_ba;
      mem_ha   = r_ha;
      mem_ua   = r_ua;
      mem_addr = r_addr;
      mem_din  = r_wdata;
    end else begin
      mem_wena = 1'b0;
      mem_addr = {AW{1'b0}};
    end
  end

  // Response registers: capture at the closing edge of ACCESS. Acks are
  // high for the single RESP cycle that follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_ack   <= 1'b0;
      ls_ack   <= 1'b0;
      ls_err   <= 1'b0;
      if_rdata <= 32'h0000_0000;
      ls_rdata <= 32'h0000_0000;
    end else if (r_state == ST_ACCESS) begin
      if (r_is_if) begin
        if_ack   <= 1'b1;
        if_rdata <= f_fetch_clip(mem_dout, r_addr);
        ls_ack   <= 1'b0;
        ls_err   <= 1'b0;
      end else begin
        if_ack   <= 1'b0;
        ls_ack   <= 1'b1;
        ls_err   <= r_err;
        ls_rdata <= (r_err | r_we) ? 32'h0000_0000
                                   : f_load_ext(mem_dout, r_ba, r_ha, r_ua);
      end
    end else begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      ls_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a byte-array memory driven by the DUT, a
// transaction-level reference model, a per-cycle compare loop, and directed
// operations with literal expected values.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we, ls_ba, ls_ha, ls_ua;
  logic [7:0]  ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic        mem_wena, mem_ba, mem_ha, mem_ua;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  mem_port_arbiter #(.IF_STARVE_MAX(STARVE), .AW(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_ba(ls_ba), .ls_ha(ls_ha), .ls_ua(ls_ua),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .ls_err(ls_err), .mem_wena(mem_wena), .mem_ba(mem_ba), .mem_ha(mem_ha),
    .mem_ua(mem_ua), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory. Its read port wraps at the top, so the DUT must clip
  // fetches itself.
  logic [7:0] mem [256];
  logic [7:0] mm  [256];   // model's own view of memory
  logic [7:0] a1, a2, a3;
  assign a1 = mem_addr + 8'd1;
  assign a2 = mem_addr + 8'd2;
  assign a3 = mem_addr + 8'd3;
  assign mem_dout = {mem[a3], mem[a2], mem[a1], mem[mem_addr]};

  int n_chk = 0;
  int n_err = 0;

  // Model state
  int k = 0;
  int next_arb = 0;
  int starve = 0;
  bit pend = 1'b0;
  int p_grant = 0;
  bit p_is_if, p_we, p_ba, p_ha, p_ua, p_err;
  int p_addr, p_size;
  logic [31:0] p_wdata;
  bit e_if_ack = 1'b0, e_ls_ack = 1'b0, e_ls_err = 1'b0, e_access = 1'b0;
  logic [31:0] e_if_rdata = 32'h0, e_ls_rdata = 32'h0;

  // Ack log
  int n_log = 0;
  byte log_kind [8];
  int  log_cyc  [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_fetch(input int addr);
    logic [31:0] v;
    v = 32'h0;
    for (int j = 0; j < 4; j++)
      if (addr + j <= 255) v = v | (32'(mm[addr + j]) << (8 * j));
    return v;
  endfunction

  function automatic logic [31:0] model_load(input int addr, input int size, input bit ua);
    longint v;
    v = 0;
    for (int j = 0; j < size; j++) v = v | (longint'(mm[addr + j]) << (8 * j));
    if (!ua && size < 4 && v >= (longint'(1) << (8 * size - 1)))
      v = v - (longint'(1) << (8 * size));
    return v[31:0];
  endfunction

  // Model: one edge at a time, in terms of grant times and byte arrays.
  task automatic model_edge();
    int  sz;
    bit  er, if_prio;
    k++;
    if (mem_wena) begin
      if (mem_ba) mem[mem_addr] <= mem_din[7:0];
      else if (mem_ha) begin
        mem[mem_addr] <= mem_din[7:0]; mem[a1] <= mem_din[15:8];
      end else begin
        mem[mem_addr] <= mem_din[7:0]; mem[a1] <= mem_din[15:8];
        mem[a2] <= mem_din[23:16]; mem[a3] <= mem_din[31:24];
      end
    end
    if (rst) begin
      pend = 1'b0; next_arb = k + 1; starve = 0;
      e_if_ack = 1'b0; e_ls_ack = 1'b0; e_ls_err = 1'b0; e_access = 1'b0;
      e_if_rdata = 32'h0; e_ls_rdata = 32'h0;
    end else begin
      e_if_ack = 1'b0; e_ls_ack = 1'b0; e_ls_err = 1'b0; e_access = 1'b0;
      if (pend && k == p_grant + 1) begin
        if (p_is_if) begin
          e_if_ack = 1'b1; e_if_rdata = model_fetch(p_addr);
        end else begin
          e_ls_ack = 1'b1; e_ls_err = p_err;
          if (p_err || p_we) e_ls_rdata = 32'h0;
          else e_ls_rdata = model_load(p_addr, p_size, p_ua);
          if (p_we && !p_err)
            for (int j = 0; j < p_size; j++) mm[p_addr + j] = p_wdata[8*j +: 8];
        end
        pend = 1'b0;
      end
      if (k >= next_arb) begin
        if_prio = (starve == STARVE) && if_req;
        if (ls_req && !if_prio) begin
          sz = ls_ba ? 1 : (ls_ha ? 2 : 4);
          er = (int'(ls_addr) + sz - 1) > 255;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
          if (sz > 1 && (int'(ls_addr) % sz) != 0) er = 1'b1;
`endif
          pend = 1'b1; p_grant = k; next_arb = k + 3; e_access = 1'b1;
          p_is_if = 1'b0; p_we = ls_we; p_ba = ls_ba; p_ha = ls_ha; p_ua = ls_ua;
          p_err = er; p_addr = int'(ls_addr); p_size = sz; p_wdata = ls_wdata;
          if (if_req && starve < STARVE) starve++;
          if (!if_req) starve = 0;
        end else if (if_req) begin
          pend = 1'b1; p_grant = k; next_arb = k + 3; e_access = 1'b1;
          p_is_if = 1'b1; p_we = 1'b0; p_ba = 1'b0; p_ha = 1'b0; p_ua = 1'b0;
          p_err = 1'b0; p_addr = int'(if_addr); p_size = 4; p_wdata = 32'h0;
          starve = 0;
        end else begin
          starve = 0;
        end
      end
    end
  endtask

  // Compare DUT against the model, away from the active edge.
  task automatic compare_cycle();
    bit exp_w;
    chk("if_ack", 32'(if_ack), 32'(e_if_ack));
    chk("ls_ack", 32'(ls_ack), 32'(e_ls_ack));
    chk("ls_err", 32'(ls_err), 32'(e_ls_err));
    if (e_if_ack) chk("if_rdata", if_rdata, e_if_rdata);
    if (e_ls_ack) chk("ls_rdata", ls_rdata, e_ls_rdata);
    exp_w = e_access && p_we && !p_err && !rst;
    chk("mem_wena", 32'(mem_wena), 32'(exp_w));
    if (exp_w) begin
      chk("mem_addr", 32'(mem_addr), 32'(p_addr));
      chk("mem_din", mem_din, p_wdata);
      chk("mem_ba", 32'(mem_ba), 32'(p_ba));
    end
    if (if_ack || ls_ack) begin
      if (n_log < 8) begin
        log_kind[n_log] = if_ack ? 8'h49 : 8'h4C;
        log_cyc[n_log]  = k;
      end
      n_log++;
    end
  endtask

  task automatic ls_op(input logic we, input logic ba, input logic ha, input logic ua,
                       input logic [7:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
    bit got;
    @(posedge clk); #1;
    ls_we = we; ls_ba = ba; ls_ha = ha; ls_ua = ua; ls_addr = addr; ls_wdata = wd;
    ls_req = 1'b1;
    got = 1'b0; lat = 0; rd = 32'h0; er = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (ls_ack) begin got = 1'b1; rd = ls_rdata; er = ls_err; end
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL ls_timeout: got no ls_ack expected ack within 20 cycles");
    end
    @(posedge clk); #1;
    ls_req = 1'b0;
  endtask

  task automatic if_op(input logic [7:0] addr, output logic [31:0] rd, output int lat);
    bit got;
    @(posedge clk); #1;
    if_addr = addr; if_req = 1'b1;
    got = 1'b0; lat = 0; rd = 32'h0;
    while (!got && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (if_ack) begin got = 1'b1; rd = if_rdata; end
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL if_timeout: got no if_ack expected ack within 20 cycles");
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wait_n;
    int          ndiff;
    string       exp_seq;

    rst = 1'b1; if_req = 1'b0; if_addr = 8'h00;
    ls_req = 1'b0; ls_we = 1'b0; ls_ba = 1'b0; ls_ha = 1'b0; ls_ua = 1'b0;
    ls_addr = 8'h00; ls_wdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h55; mem[8'h01] = 8'h66;
    mem[8'h04] = 8'h93; mem[8'h05] = 8'h00; mem[8'h06] = 8'h00; mem[8'h07] = 8'h08;
    mem[8'h10] = 8'h93; mem[8'h11] = 8'h80;
    mem[8'h20] = 8'h44; mem[8'h21] = 8'h33; mem[8'h22] = 8'h22; mem[8'h23] = 8'h11;
    mem[8'hFC] = 8'hD4; mem[8'hFD] = 8'hC3; mem[8'hFE] = 8'hB2; mem[8'hFF] = 8'hA1;
    for (int i = 0; i < 256; i++) mm[i] = mem[i];

    repeat (2) @(posedge clk);
    #1;
    fork
      forever begin @(posedge clk); model_edge(); end
      forever begin @(negedge clk); compare_cycle(); end
    join_none
    @(posedge clk); #1;

    // Reset state
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_ls_ack", 32'(ls_ack), 32'd0);
    chk("rst_ls_err", 32'(ls_err), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    chk("rst_mem_wena", 32'(mem_wena), 32'd0);
    rst = 1'b0;

    // Fetch
    if_op(8'h04, rd, lat);
    chk("fetch_data", rd, 32'h08000093);
    chk("fetch_lat", 32'(lat), 32'd2);

    // Byte/half loads, signed and unsigned
    ls_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0, rd, er, lat);
    chk("lb_signed", rd, 32'hFFFFFF93);
    chk("lb_lat", 32'(lat), 32'd2);
    ls_op(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 32'h0, rd, er, lat);
    chk("lb_unsigned", rd, 32'h00000093);
    ls_op(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 32'h0, rd, er, lat);
    chk("lh_signed", rd, 32'hFFFF8093);
    ls_op(1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 32'h0, rd, er, lat);
    chk("lh_unsigned", rd, 32'h00008093);

    // Store half, then word load
    ls_op(1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 32'h1234BEEF, rd, er, lat);
    chk("sh_rdata", rd, 32'h0);
    chk("sh_err", 32'(er), 32'd0);
    ls_op(1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 32'h0, rd, er, lat);
    chk("lw_after_sh", rd, 32'h0000BEEF);
    chk("lw_after_sh_err", 32'(er), 32'd0);

    // Boundary
    ls_op(1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 32'hCAFEF00D, rd, er, lat);
    chk("sw_fe_err", 32'(er), 32'd1);
    chk("sw_fe_rdata", rd, 32'h0);
    chk("sw_fe_lat", 32'(lat), 32'd2);
    chk("mem_fe_kept", 32'(mem[8'hFE]), 32'h000000B2);
    chk("mem_ff_kept", 32'(mem[8'hFF]), 32'h000000A1);
    ls_op(1'b0, 1'b0, 1'b0, 1'b0, 8'hFC, 32'h0, rd, er, lat);
    chk("lw_fc_err", 32'(er), 32'd0);
    chk("lw_fc_data", rd, 32'hA1B2C3D4);
    ls_op(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 32'h0, rd, er, lat);
    chk("lbu_ff_err", 32'(er), 32'd0);
    chk("lbu_ff_data", rd, 32'h000000A1);
    ls_op(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 32'h0, rd, er, lat);
    chk("lhu_ff_err", 32'(er), 32'd1);
    chk("lhu_ff_data", rd, 32'h0);

    // Fetch past the top: missing bytes read as zero
    if_op(8'hFE, rd, lat);
    chk("fetch_top_clip", rd, 32'h0000A1B2);

    // Contention: both held; expect LS x4, IF, LS, 3 cycles apart
    n_log = 0;
    @(posedge clk); #1;
    ls_we = 1'b0; ls_ba = 1'b0; ls_ha = 1'b0; ls_ua = 1'b0; ls_addr = 8'h10;
    if_addr = 8'h04;
    ls_req = 1'b1; if_req = 1'b1;
    wait_n = 0;
    while (n_log < 6 && wait_n < 40) begin @(negedge clk); wait_n++; end
    if (n_log < 6) begin
      n_chk++; n_err++;
      $display("FAIL contention_timeout: got %0d acks expected 6", n_log);
    end
    @(posedge clk); #1;
    ls_req = 1'b0; if_req = 1'b0;
    exp_seq = "LLLLIL";
    for (int i = 0; i < 6; i++)
      chk($sformatf("grant_order_%0d", i), 32'(log_kind[i]), 32'(exp_seq[i]));
    for (int i = 0; i < 5; i++)
      chk($sformatf("grant_gap_%0d", i), 32'(log_cyc[i+1] - log_cyc[i]), 32'd3);
    repeat (2) @(posedge clk);

    // Reset during the ACCESS cycle of a word store
    n_log = 0;
    @(posedge clk); #1;
    ls_we = 1'b1; ls_ba = 1'b0; ls_ha = 1'b0; ls_addr = 8'h20; ls_wdata = 32'hCAFEBABE;
    ls_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_access_wena", 32'(mem_wena), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_ack", 32'(n_log), 32'd0);
    chk("rst_mem_kept", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h11223344);

    // Misaligned word load
    ls_op(1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 32'h0, rd, er, lat);
    chk("lw_22_lat", 32'(lat), 32'd2);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    chk("lw_22_err", 32'(er), 32'd1);
    chk("lw_22_data", rd, 32'h0);
`else
    chk("lw_22_err", 32'(er), 32'd0);
    chk("lw_22_data", rd, 32'h00001122);
`endif

    repeat (4) @(posedge clk);
    #1;
    ndiff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) ndiff++;
    chk("mem_image", 32'(ndiff), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
